layer_sequencer: RTL
====================

# layer_sequencer

Time-multiplexes one `neuron_run` datapath across the `M` neurons of a fully-connected layer. It latches an `N`-wide input vector through a valid/ready handshake. For each neuron in turn it fetches the weight row and activation bounds from a synchronous parameter memory, evaluates the neuron and stores its `zero2one_t` output. When all `M` outputs are ready it presents them as one vector with its own valid/ready handshake. It sits between layer-to-layer buffering and the parameter ROM/RAM.

## Interface
- `N`, 16, inputs per neuron (passed to `neuron_run`)
- `M`, 8, neurons per layer; legal range is 1 or more
- `AW`, `$clog2(M)` (minimum 1), parameter memory address width
- `clk`  in  1  clock; all state changes on its rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `abort`  in  1  synchronous; returns the block to IDLE from any state
- `in_valid`  in  1  input vector valid
- `in_ready`  out  1  high only in IDLE
- `in_vec`  in  `zero2one_t [N-1:0]`  layer input
- `mem_en`  out  1  parameter memory read strobe
- `mem_addr`  out  AW  neuron index being read
- `mem_weights`  in  `frac_t [N-1:0]`  weight row; valid 1 cycle after `mem_en`
- `mem_act_max`, `mem_act_min`  in  `frac_t`  activation bounds; same timing as `mem_weights`
- `out_valid`  out  1  output vector valid
- `out_ready`  in  1  downstream accepts
- `out_vec`  out  `zero2one_t [M-1:0]`  layer output
- `busy`  out  1  high in FETCH, LOAD, EVAL and DONE

## Operation
- FSM states: IDLE, FETCH, LOAD, EVAL, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid`: latch `in_vec` into `in_q`, set `idx=0`, go to FETCH.
- **FETCH**
  - `mem_en=1`, `mem_addr=idx`.
  - Go to LOAD.
- **LOAD**
  - Register `mem_weights`, `mem_act_max` and `mem_act_min` into `w_q`, `max_q` and `min_q`.
  - Go to EVAL.
- **EVAL**
  - The `neuron_run` instance is driven from `in_q`, `w_q`, `max_q` and `min_q`.
  - Write its `out` into `out_q[idx]`.
  - If `idx==M-1`, go to DONE; otherwise `idx++` and go to FETCH.
- **DONE**
  - `out_valid=1`; `out_vec=out_q`.
  - On `out_ready`, go to IDLE.
  - `in_ready` stays 0 in DONE; there is no overlap with the next input.
- `in_q` does not change outside IDLE. `out_q` entries not yet written in the current pass keep their previous-pass value.
- `abort` has priority over every transition.
  - `idx` returns to 0 and the state to IDLE.
  - `out_q` is not cleared.
  - An `abort` in the same cycle as an IDLE handshake wins: nothing is latched and `in_ready` is still 1 that cycle.
- `mem_en` is 0 in every state except FETCH. `mem_addr` holds `idx` in all states.

## Timing
- Reset values:
  - State IDLE, `idx=0`, `in_q=0`, `w_q=0`, `max_q=0`, `min_q=0`, `out_q` all `` `zero2one_min ``.
  - `in_ready=1`, `out_valid=0`, `mem_en=0`, `busy=0`.
- Per neuron: 3 cycles (FETCH, LOAD, EVAL).
- Input accept to `out_valid` high: 3M+1 cycles. With M=8 that is 25.
- `out_valid` and `out_vec` are stable while `out_ready=0`.
- Throughput when downstream always accepts: one vector per 3M+2 cycles.
- Asserting `rst_n` low mid-pass clears everything immediately, regardless of `clk`.

## Configuration
- Macro `LAYER_SEQ_SAT_COUNT_EN`.
- Defined:
  - Adds outputs `sat_hi_cnt` and `sat_lo_cnt`, each `[$clog2(M+1)-1:0]`.
  - They count the EVAL cycles in which `neuron_run` reports `sum_too_big` or `sum_too_small` respectively.
  - Both clear when an input is accepted, and are valid and held in DONE.
  - Reset value 0; `abort` clears them.
- Undefined: the ports and counters do not exist. The `sum_too_*` outputs of the instance are left unconnected.

## Structure
- `layer_seq_state_t` enum goes in the shared defs alongside `frac_t` and `zero2one_t`.
- Per-neuron cycle count of 3 is the shared constant `` `LAYER_SEQ_CYCLES_PER_NEURON ``.
- One sub-module: a single `neuron_run #(.N(N))` instance.

## Test plan
- **Single pass, M=2, N=2**
  - Stimulus: `in_vec={max,max}`. Neuron 0 weights `{0.5,0.5}` with bounds min 0 / max 1.0; neuron 1 weights `{-1.0,0}` with min 0.
  - Required: `out_vec[0]` = `zero2one_max`, `out_vec[1]` = `zero2one_min`; `out_valid` exactly 7 cycles after accept.
- **Memory protocol**
  - Required: `mem_en` pulses exactly M times with `mem_addr` = 0,1,…,M-1 in order.
  - Corrupting `mem_weights` outside the cycle after `mem_en` changes no output.
- **Backpressure**
  - Stimulus: hold `out_ready=0` for 10 cycles in DONE, with `in_valid=1` throughout.
  - Required: `out_vec` stable and `in_ready=0` throughout; IDLE one cycle after `out_ready`.
- **Abort mid-pass**
  - Stimulus: `abort` in LOAD of neuron 1.
  - Required: IDLE next cycle, `idx=0`, no `out_valid`; the next pass completes normally.
- **Async reset**
  - Stimulus: `rst_n` low between clock edges during EVAL.
  - Required: `busy=0` and `out_valid=0` immediately; reset values everywhere.
- **`LAYER_SEQ_SAT_COUNT_EN`, M=4**
  - Stimulus: bounds chosen so 2 neurons saturate high and 1 low.
  - Required: `sat_hi_cnt=2`, `sat_lo_cnt=1` in DONE.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared definitions for the layer sequencer: fixed-point types, FSM state
// encoding and the per-neuron cycle constant.
// zero2one_t is an unsigned fraction, 0 -> 0.0, 255 -> ~1.0.
// frac_t is signed with FRAC_FBITS fractional bits, so 1.0 == 16384.

`ifndef LAYER_SEQ_DEFS_SV
`define LAYER_SEQ_DEFS_SV
`define ZERO2ONE_MIN 8'h00
`define ZERO2ONE_MAX 8'hFF
`define LAYER_SEQ_CYCLES_PER_NEURON 3
`endif

package layer_seq_pkg;

  localparam int FRAC_W     = 16;
  localparam int FRAC_FBITS = 14;
  localparam int Z2O_W      = 8;

  typedef logic signed [FRAC_W-1:0] frac_t;
  typedef logic        [Z2O_W-1:0]  zero2one_t;

  localparam zero2one_t Z2O_MIN = `ZERO2ONE_MIN;
  localparam zero2one_t Z2O_MAX = `ZERO2ONE_MAX;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EVAL,
    ST_DONE
  } layer_seq_state_t;

  // Cycles from input accept until out_valid is first seen high.
  function automatic int unsigned layer_seq_latency(input int unsigned m);
    return `LAYER_SEQ_CYCLES_PER_NEURON * m + 1;
  endfunction

endpackage

// File: rtl/layer_sequencer_neuron_run.sv
// neuron_run: combinational evaluation of a single neuron.
// The dot product of the input vector (unsigned fraction) and the weight row
// is rescaled to frac_t precision (floor), clamped to [act_min, act_max] and
// converted to zero2one_t. The saturation flags report which bound clamped.

module neuron_run
  import layer_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  zero2one_t [N-1:0] in_vec,
  input  frac_t     [N-1:0] weights,
  input  frac_t             act_max,
  input  frac_t             act_min,
  output zero2one_t         out,
  output logic              sum_too_big,
  output logic              sum_too_small
);

  // Wide enough for N products of a 9-bit signed input and a 16-bit weight.
  localparam int SW = FRAC_W + Z2O_W + 2 + $clog2(N);

  logic signed [SW-1:0] acc;
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] hi_ext;
  logic signed [SW-1:0] lo_ext;
  logic signed [SW-1:0] clamped;
  logic signed [SW-1:0] scaled;

  // Multiply-accumulate over the whole row.
  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + SW'(signed'({1'b0, in_vec[i]})) * SW'(signed'(weights[i]));
    end
  end

  // Rescale, clamp and convert to the unsigned output fraction.
  always_comb begin
    sum_q         = acc >>> Z2O_W;
    hi_ext        = SW'(signed'(act_max));
    lo_ext        = SW'(signed'(act_min));
    sum_too_big   = (sum_q > hi_ext);
    sum_too_small = (sum_q < lo_ext);
    if (sum_too_big) begin
      clamped = hi_ext;
    end else if (sum_too_small) begin
      clamped = lo_ext;
    end else begin
      clamped = sum_q;
    end
    scaled = clamped >>> (FRAC_FBITS - Z2O_W);
    if (clamped < 0) begin
      out = Z2O_MIN;
    end else if (scaled > SW'(signed'({1'b0, Z2O_MAX}))) begin
      out = Z2O_MAX;
    end else begin
      out = scaled[Z2O_W-1:0];
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs one neuron_run datapath across the M neurons of a
// fully-connected layer, fetching each weight row from a synchronous
// parameter memory (data valid one cycle after mem_en).
// Optional feature macro: LAYER_SEQ_SAT_COUNT_EN adds sat_hi_cnt/sat_lo_cnt.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for an input vector, in_ready high
// ST_FETCH | mem_en high, reading row idx
// ST_LOAD  | memory data captured into w_q / max_q / min_q
// ST_EVAL  | neuron_run output written to out_q[idx]
// ST_DONE  | out_vec presented with out_valid until out_ready

module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int N  = 16,
  parameter int M  = 8,
  parameter int AW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  zero2one_t [N-1:0]    in_vec,
  output logic                 mem_en,
  output logic      [AW-1:0]   mem_addr,
  input  frac_t     [N-1:0]    mem_weights,
  input  frac_t                mem_act_max,
  input  frac_t                mem_act_min,
  output logic                 out_valid,
  input  logic                 out_ready,
  output zero2one_t [M-1:0]    out_vec,
  output logic                 busy
`ifdef LAYER_SEQ_SAT_COUNT_EN
  ,
  output logic [$clog2(M+1)-1:0] sat_hi_cnt,
  output logic [$clog2(M+1)-1:0] sat_lo_cnt
`endif
);

  localparam logic [AW-1:0] LAST_IDX = AW'(M - 1);

  layer_seq_state_t     state;
  logic      [AW-1:0]   idx;
  zero2one_t [N-1:0]    in_q;
  frac_t     [N-1:0]    w_q;
  frac_t                max_q;
  frac_t                min_q;
  zero2one_t [M-1:0]    out_q;
  zero2one_t            nr_out;

  assign mem_addr = idx;
  assign out_vec  = out_q;

`ifdef LAYER_SEQ_SAT_COUNT_EN
  localparam int CW = $clog2(M + 1);

  logic nr_too_big;
  logic nr_too_small;

  neuron_run #(.N(N)) u_neuron (
    .in_vec        (in_q),
    .weights       (w_q),
    .act_max       (max_q),
    .act_min       (min_q),
    .out           (nr_out),
    .sum_too_big   (nr_too_big),
    .sum_too_small (nr_too_small)
  );

  // Count saturating evaluations of the current pass; cleared on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else if (abort) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else if (state == ST_IDLE && in_valid) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else if (state == ST_EVAL) begin
      if (nr_too_big) begin
        sat_hi_cnt <= sat_hi_cnt + CW'(1);
      end
      if (nr_too_small) begin
        sat_lo_cnt <= sat_lo_cnt + CW'(1);
      end
    end
  end
`else
  neuron_run #(.N(N)) u_neuron (
    .in_vec        (in_q),
    .weights       (w_q),
    .act_max       (max_q),
    .act_min       (min_q),
    .out           (nr_out),
    .sum_too_big   (),
    .sum_too_small ()
  );
`endif

  // Sequencer FSM with registered handshake and memory strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      in_q      <= '0;
      w_q       <= '0;
      max_q     <= '0;
      min_q     <= '0;
      out_q     <= {M{Z2O_MIN}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mem_en    <= 1'b0;
      busy      <= 1'b0;
    end else if (abort) begin
      // out_q deliberately survives an abort.
      state     <= ST_IDLE;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mem_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_q     <= in_vec;
            idx      <= '0;
            state    <= ST_FETCH;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            mem_en   <= 1'b1;
          end
        end
        ST_FETCH: begin
          state  <= ST_LOAD;
          mem_en <= 1'b0;
        end
        ST_LOAD: begin
          w_q   <= mem_weights;
          max_q <= mem_act_max;
          min_q <= mem_act_min;
          state <= ST_EVAL;
        end
        ST_EVAL: begin
          out_q[idx] <= nr_out;
          if (idx == LAST_IDX) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end else begin
            idx    <= idx + AW'(1);
            state  <= ST_FETCH;
            mem_en <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          idx       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          mem_en    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
